// File: rtl/io_port_pkg.sv
// Shared definitions for the I/O port bank arbiter: FSM encoding, bank
// geometry, default address map and error code meaning.
package io_port_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Port bank geometry
  localparam int NUM_PORTS = 16;
  localparam int PORT_W    = 8;
  localparam int BANK_W    = NUM_PORTS * PORT_W;

  // Default address map (both windows 16-aligned)
  localparam logic [7:0] DEF_OUT_BASE = 8'hE0;
  localparam logic [7:0] DEF_IN_BASE  = 8'hF0;

  // err flag meaning, valid alongside ack
  localparam logic ERR_OK      = 1'b0;  // access performed
  localparam logic ERR_ILLEGAL = 1'b1;  // write to input port or unmapped address

  // Width of a requester index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import io_port_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;
  logic           found;

  // Scan candidates starting at ptr; the first pending one wins
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        winner                   = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/io_port_arbiter.sv
// Round-robin arbiter and access sequencer for the shared 8-bit I/O port
// bank. Owns the 16 output port registers; input ports are sampled directly.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for requests; latch winner's transaction, raise gnt
// ST_ACCESS | decode latched address, perform port write/read, set err
// ST_RESP   | pulse ack to the winner, rotate rr_ptr past it, drop gnt
module io_port_arbiter
  import io_port_pkg::*;
#(
  parameter int         NUM_REQ  = 2,
  parameter logic [7:0] OUT_BASE = DEF_OUT_BASE,
  parameter logic [7:0] IN_BASE  = DEF_IN_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [8*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [7:0]            rdata,
  input  logic [BANK_W-1:0]     port_in,
  output logic [BANK_W-1:0]     port_out
);

  localparam int               IDX_W    = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Elaboration-time sanity of the parameter set
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("io_port_arbiter: NUM_REQ must be in 2..8");
    end
    if (OUT_BASE[3:0] != 4'h0 || IN_BASE[3:0] != 4'h0) begin : g_bad_align
      $error("io_port_arbiter: OUT_BASE and IN_BASE must be 16-aligned");
    end
    if (OUT_BASE[7:4] == IN_BASE[7:4]) begin : g_bad_overlap
      $error("io_port_arbiter: OUT_BASE and IN_BASE must be distinct");
    end
  endgenerate

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_winner;
  logic                 arb_any;

  logic                 lat_we;
  logic [7:0]           lat_addr;
  logic [PORT_W-1:0]    lat_wdata;
  logic [IDX_W-1:0]     lat_idx;

  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   ack_d;
  logic                 err_q;
  logic [PORT_W-1:0]    rdata_q;
  logic [BANK_W-1:0]    port_q;

  logic [3:0]           acc_off;
  logic                 hit_out;
  logic                 hit_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_ptr),
    .grant  (arb_grant),
    .winner (arb_winner),
    .any    (arb_any)
  );

  // Window decode of the latched address; offset is the low nibble
  assign acc_off = lat_addr[3:0];
  assign hit_out = (lat_addr[7:4] == OUT_BASE[7:4]);
  assign hit_in  = (lat_addr[7:4] == IN_BASE[7:4]);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every granted transaction runs to completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_any) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered gnt/ack handshake lines
  always_comb begin
    gnt_d = '0;
    ack_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) gnt_d = arb_grant;
      end
      ST_ACCESS: begin
        gnt_d = gnt_q;
      end
      ST_RESP: begin
        // gnt_q is the one-hot of the winner, so it doubles as the ack vector
        ack_d = gnt_q;
      end
      default: begin
        gnt_d = '0;
        ack_d = '0;
      end
    endcase
  end

  // Registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q <= '0;
      ack_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ack_q <= ack_d;
    end
  end

  // Datapath: transaction latch, port registers, read data, error, rr pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_idx   <= '0;
      port_q    <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            lat_we    <= req_we[arb_winner];
            lat_addr  <= req_addr[{arb_winner, 3'b000} +: 8];
            lat_wdata <= req_wdata[{arb_winner, 3'b000} +: PORT_W];
            lat_idx   <= arb_winner;
          end
        end
        ST_ACCESS: begin
          if (hit_out) begin
            err_q <= ERR_OK;
            if (lat_we) begin
              port_q[{acc_off, 3'b000} +: PORT_W] <= lat_wdata;
            end else begin
              rdata_q <= port_q[{acc_off, 3'b000} +: PORT_W];
            end
          end else if (hit_in) begin
            if (lat_we) begin
              // Input ports are read-only; leave rdata alone
              err_q <= ERR_ILLEGAL;
            end else begin
              rdata_q <= port_in[{acc_off, 3'b000} +: PORT_W];
              err_q   <= ERR_OK;
            end
          end else begin
            rdata_q <= '0;
            err_q   <= ERR_ILLEGAL;
          end
        end
        ST_RESP: begin
          rr_ptr <= (lat_idx == LAST_IDX) ? '0 : lat_idx + IDX_W'(1);
        end
        default: begin
          rr_ptr <= rr_ptr;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign port_out = port_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Self-checking bench for io_port_arbiter (NUM_REQ=2): directed vector table,
// hand-written multi-cycle sequences and a randomized transaction-level model.
module tb_io_port_arbiter;

  localparam int         N  = 2;
  localparam logic [7:0] OB = 8'hE0;
  localparam logic [7:0] IB = 8'hF0;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req, req_we, gnt, ack;
  logic [8*N-1:0]   req_addr, req_wdata;
  logic             err;
  logic [7:0]       rdata;
  logic [127:0]     port_in, port_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_port_arbiter #(.NUM_REQ(N), .OUT_BASE(OB), .IN_BASE(IB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .port_in   (port_in),
    .port_out  (port_out)
  );

  typedef struct {
    int         r;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] pin0;
    logic [7:0] pin15;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         pidx;
    logic [7:0] pval;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic we, input logic [7:0] a, input logic [7:0] d);
    req[r]              = 1'b1;
    req_we[r]           = we;
    req_addr[r*8 +: 8]  = a;
    req_wdata[r*8 +: 8] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Advance until ack is seen (bounded); n counts negedges waited
  task automatic wait_ack(inout int n);
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 10);
  endtask

  task automatic rand_txn(output logic we, output logic [7:0] a, output logic [7:0] d);
    int cat;
    cat = $urandom_range(0, 9);
    we  = 1'($urandom_range(0, 1));
    d   = 8'($urandom);
    if (cat < 6)      a = OB + 8'($urandom_range(0, 15));
    else if (cat < 8) a = IB + 8'($urandom_range(0, 15));
    else              a = 8'($urandom_range(0, 8'hDF));
  endtask

  initial begin
    int n, k, w, c;
    logic [7:0]   mport[16];
    logic [7:0]   mrd;
    logic         merr;
    int           mptr;
    logic         pv[N];
    logic         pwe[N];
    logic [7:0]   pa[N], pd[N];
    logic [127:0] exp_po;
    logic [7:0]   a;

    vecs[0]  = '{0, 1'b1, 8'hE3, 8'h0E, 8'h00, 8'h00, 1'b0, 8'h00,  3, 8'h0E};
    vecs[1]  = '{0, 1'b0, 8'hE3, 8'h00, 8'h00, 8'h00, 1'b0, 8'h0E,  3, 8'h0E};
    vecs[2]  = '{1, 1'b0, 8'hF0, 8'h00, 8'h0E, 8'h00, 1'b0, 8'h0E,  3, 8'h0E};
    vecs[3]  = '{0, 1'b1, 8'hF2, 8'h55, 8'h00, 8'h00, 1'b1, 8'h0E,  2, 8'h00};
    vecs[4]  = '{1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00,  3, 8'h0E};
    vecs[5]  = '{1, 1'b1, 8'hEF, 8'hAB, 8'h00, 8'h00, 1'b0, 8'h00, 15, 8'hAB};
    vecs[6]  = '{0, 1'b0, 8'hEF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hAB, 15, 8'hAB};
    vecs[7]  = '{1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h3C, 1'b0, 8'h3C, 15, 8'hAB};
    vecs[8]  = '{1, 1'b0, 8'hF5, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A,  5, 8'h00};
    vecs[9]  = '{1, 1'b1, 8'hDF, 8'h11, 8'h00, 8'h00, 1'b1, 8'h00, 15, 8'hAB};
    vecs[10] = '{0, 1'b1, 8'hE0, 8'h77, 8'h00, 8'h00, 1'b0, 8'h00,  0, 8'h77};
    vecs[11] = '{1, 1'b0, 8'hF3, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A,  0, 8'h77};
    vecs[12] = '{0, 1'b0, 8'hE0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h77,  0, 8'h77};

    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    port_in   = '0;

    // Reset / idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_port_out", port_out, '0);
      chk("idle_gnt_ack_err_rdata", {gnt, ack, err, rdata}, '0);
    end

    // Directed vector table, one requester at a time
    for (int v = 0; v < 13; v++) begin
      port_in = {vecs[v].pin15, {14{8'h5A}}, vecs[v].pin0};
      drive(vecs[v].r, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt_first", v), gnt, 1 << vecs[v].r);
      chk($sformatf("vec%0d_ack_early", v), ack, '0);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt_held", v), gnt, 1 << vecs[v].r);
      chk($sformatf("vec%0d_port", v), port_out[vecs[v].pidx*8 +: 8], vecs[v].pval);
      n = 2;
      wait_ack(n);
      chk($sformatf("vec%0d_ack_latency", v), n, 3);
      chk($sformatf("vec%0d_ack", v), ack, 1 << vecs[v].r);
      chk($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_gnt_clear", v), gnt, '0);
      req = '0;
    end

    // Reset during ACCESS of a write to E5 (rr_ptr was 1 at this point)
    drive(0, 1'b1, 8'hE5, 8'h99);
    @(negedge clk);
    chk("midrst_gnt", gnt, 2'b01);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("midrst_port_out", port_out, '0);
    chk("midrst_gnt_ack", {gnt, ack}, '0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_ack", ack, '0);
      chk("midrst_port5", port_out[47:40], 8'h00);
    end

    // Contention: both write continuously to E0; order must start at 0
    drive(0, 1'b1, 8'hE0, 8'h5A);
    drive(1, 1'b1, 8'hE0, 8'hC3);
    k = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        chk("fair_ack_order", ack, 1 << (k % 2));
        chk("fair_ack_spacing", cyc, 3 * (k + 1));
        chk("fair_port0", port_out[7:0], (k % 2 == 0) ? 8'h5A : 8'hC3);
        k++;
      end
    end
    req = '0;
    chk("fair_ack_count", k, 4);

    // Post-reset request from requester 1 served normally
    drive(1, 1'b0, 8'hE0, 8'h00);
    n = 0;
    wait_ack(n);
    chk("post_rst_latency", n, 3);
    chk("post_rst_ack", ack, 2'b10);
    chk("post_rst_rdata", rdata, 8'hC3);
    chk("post_rst_err", err, 1'b0);
    req = '0;

    // Randomized transactions against a transaction-level model
    do_reset();
    for (int p = 0; p < 16; p++) mport[p] = 8'h00;
    mrd  = 8'h00;
    merr = 1'b0;
    mptr = 0;
    for (int r = 0; r < N; r++) begin
      pv[r] = 1'($urandom_range(0, 1));
      rand_txn(pwe[r], pa[r], pd[r]);
    end
    for (int t = 0; t < 300; t++) begin
      if (!pv[0] && !pv[1]) begin
        c = $urandom_range(0, N - 1);
        pv[c] = 1'b1;
        rand_txn(pwe[c], pa[c], pd[c]);
      end
      for (int r = 0; r < N; r++) begin
        req[r]              = pv[r];
        req_we[r]           = pwe[r];
        req_addr[r*8 +: 8]  = pa[r];
        req_wdata[r*8 +: 8] = pd[r];
      end
      port_in = {$urandom, $urandom, $urandom, $urandom};

      w = -1;
      for (int i = 0; i < N; i++) begin
        c = (mptr + i) % N;
        if (w < 0 && pv[c]) w = c;
      end
      a = pa[w];
      if (a >= OB && a <= OB + 8'd15) begin
        merr = 1'b0;
        if (pwe[w]) mport[a - OB] = pd[w];
        else        mrd = mport[a - OB];
      end else if (a >= IB && a <= IB + 8'd15) begin
        if (pwe[w]) merr = 1'b1;
        else begin
          merr = 1'b0;
          mrd  = port_in[(a - IB) * 8 +: 8];
        end
      end else begin
        merr = 1'b1;
        mrd  = 8'h00;
      end
      for (int p = 0; p < 16; p++) exp_po[p*8 +: 8] = mport[p];

      n = 0;
      wait_ack(n);
      chk("rand_latency", n, 3);
      chk("rand_ack", ack, 1 << w);
      chk("rand_err", err, merr);
      chk("rand_rdata", rdata, mrd);
      chk("rand_port_out", port_out, exp_po);

      mptr  = (w + 1) % N;
      pv[w] = ($urandom_range(0, 3) != 0);
      if (pv[w]) rand_txn(pwe[w], pa[w], pd[w]);
      for (int r = 0; r < N; r++) begin
        if (r != w && !pv[r] && $urandom_range(0, 1) == 1) begin
          pv[r] = 1'b1;
          rand_txn(pwe[r], pa[r], pd[r]);
        end
      end
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
